// File: rtl/program_counter.sv
// Instruction-fetch program counter: steps by STEP each clock, with stall, absolute
// jump and relative branch, plus one-cycle wrap and misalignment flags.
module program_counter #(
    parameter int                WIDTH       = 32,
    parameter int                STEP        = 4,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch,
    input  logic [WIDTH-1:0] branch_offset,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             wrapped,
    output logic             misaligned
);

    // Low address bits that must be zero for an instruction-aligned PC.
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(STEP - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrapped_q, wrapped_d;
    logic             misaligned_q, misaligned_d;
    logic [WIDTH:0]   branch_sum;
    logic [WIDTH:0]   inc_sum;

    always_comb begin
        count_d      = count_q;
        wrapped_d    = 1'b0;
        misaligned_d = 1'b0;
        branch_sum   = {1'b0, count_q} + {1'b0, branch_offset};
        inc_sum      = {1'b0, count_q} + (WIDTH+1)'(STEP);

        if (stall) begin
            count_d = count_q;
        end else if (jump) begin
            count_d      = jump_target & ~LOW_MASK;
            misaligned_d = |(jump_target & LOW_MASK);
        end else if (branch) begin
            count_d      = branch_sum[WIDTH-1:0] & ~LOW_MASK;
            misaligned_d = |(branch_sum[WIDTH-1:0] & LOW_MASK);
            // A negative offset borrows exactly when the unsigned add does not carry.
            wrapped_d    = branch_offset[WIDTH-1] ? ~branch_sum[WIDTH] : branch_sum[WIDTH];
        end else begin
            count_d   = inc_sum[WIDTH-1:0];
            wrapped_d = inc_sum[WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= RESET_VALUE;
            wrapped_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            wrapped_q    <= wrapped_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign count      = count_q;
    assign count_next = reset ? RESET_VALUE : count_d;
    assign wrapped    = wrapped_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: directed scenarios then random control mixes,
// checked against an arithmetic reference model.
module tb_program_counter;

    localparam int STEP = 4;

    typedef struct packed {
        logic [31:0] c;
        logic        w;
        logic        m;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        branch = 1'b0;
    logic [31:0] branch_offset = '0;
    logic [31:0] count, count_next;
    logic        wrapped, misaligned;

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        exp_q[$];
    logic [31:0] mc = '0;   // model PC

    program_counter #(.WIDTH(32), .STEP(STEP), .RESET_VALUE(32'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump),
        .jump_target(jump_target), .branch(branch), .branch_offset(branch_offset),
        .count(count), .count_next(count_next), .wrapped(wrapped), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural PC.
    task automatic model(input logic s, input logic j, input logic [31:0] jt,
                         input logic b, input logic [31:0] off,
                         output logic [31:0] nxt, output logic w, output logic m);
        longint      sum;
        logic [31:0] raw;
        w = 1'b0;
        m = 1'b0;
        if (s) begin
            nxt = mc;
        end else if (j) begin
            m   = (jt % STEP) != 0;
            nxt = jt - (jt % STEP);
        end else begin
            sum = b ? longint'(mc) + longint'($signed(off)) : longint'(mc) + STEP;
            w   = (sum < 0) || (sum > 64'sh0000_0000_FFFF_FFFF);
            raw = sum[31:0];
            m   = b && ((raw % STEP) != 0);
            nxt = raw - (raw % STEP);
        end
    endtask

    // Called at a negedge; applies one set of controls across the next posedge.
    task automatic step(input logic s, input logic j, input logic [31:0] jt,
                        input logic b, input logic [31:0] off);
        exp_t e;
        stall = s; jump = j; jump_target = jt; branch = b; branch_offset = off;
        model(s, j, jt, b, off, e.c, e.w, e.m);
        #1;
        chk("count_next", count_next, e.c);
        exp_q.push_back(e);
        mc = e.c;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    // Monitor: every edge that has an outstanding expectation is checked just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("count", count, e.c);
                chk("wrapped", {31'b0, wrapped}, {31'b0, e.w});
                chk("misaligned", {31'b0, misaligned}, {31'b0, e.m});
            end
        end
    end

    initial begin
        logic        s, j, b;
        logic [31:0] jt, off;

        // Held reset: checked between and just after edges.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_count_neg", count, 32'h0);
            chk("reset_next", count_next, 32'h0);
            @(posedge clk); #1;
            chk("reset_count_pos", count, 32'h0);
            chk("reset_flags", {30'b0, wrapped, misaligned}, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        mc = '0;

        repeat (4) idle();                          // 4, 8, 12, 16
        step(1'b1, 1'b0, '0, 1'b0, '0);             // stall
        step(1'b1, 1'b1, 32'h40, 1'b1, 32'h8);      // stall beats everything
        idle();                                     // 20
        step(1'b0, 1'b1, 32'h100, 1'b0, '0);
        step(1'b0, 1'b1, 32'h103, 1'b0, '0);        // masked, misaligned
        step(1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFF8);  // 0x100 - 8 -> 0xF8
        step(1'b0, 1'b0, '0, 1'b1, 32'h6);          // misaligned branch
        step(1'b0, 1'b1, 32'h200, 1'b1, 32'h40);    // jump wins
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, '0);
        idle();                                     // wraps to 0
        idle();                                     // wrapped clears
        step(1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFF0);  // borrow below 0
        step(1'b0, 1'b1, 32'h0, 1'b0, '0);
        repeat (16) idle();                         // reach 0x40
        chk("pre_async", count, 32'h40);

        // Asynchronous reset in the middle of the low phase.
        #2;
        reset = 1'b1;
        #1;
        chk("async_count", count, 32'h0);
        chk("async_next", count_next, 32'h0);
        @(negedge clk);
        chk("async_hold", count, 32'h0);
        chk("async_flags", {30'b0, wrapped, misaligned}, 32'h0);
        reset = 1'b0;
        mc = '0;

        for (int i = 0; i < 400; i++) begin
            s   = ($urandom_range(7) == 0);
            j   = ($urandom_range(3) == 0);
            b   = ($urandom_range(2) == 0);
            jt  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            off = ($urandom_range(1) == 0) ? $urandom : 32'($signed(32'($urandom_range(64))) - 32);
            step(s, j, jt, b, off);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
